// File: rtl/uart_bus_arbiter.sv
// uart_bus_arbiter: shares the single UART register slave port between
// NUM_MASTERS bus masters. Arbitration is round-robin with zero-cycle grant.
// A request the slave does not grant at once is locked until it is granted.
// A locked request that waits too long is answered with an error response.
// Each response is routed back to the master that was granted.
module uart_bus_arbiter #(
  parameter int          NUM_MASTERS  = 2,
  parameter int          WAIT_TIMEOUT = 16,
  parameter logic [31:0] ERR_RDATA    = 32'hBAD0_0ADD
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_MASTERS-1:0]    m_req,
  input  logic [NUM_MASTERS-1:0]    m_we,
  input  logic [4*NUM_MASTERS-1:0]  m_be,
  input  logic [32*NUM_MASTERS-1:0] m_addr,
  input  logic [32*NUM_MASTERS-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]    m_gnt,
  output logic [NUM_MASTERS-1:0]    m_rvalid,
  output logic [31:0]               m_rdata,
  output logic                      m_err,
  output logic                      s_req,
  output logic                      s_we,
  output logic [3:0]                s_be,
  output logic [31:0]               s_addr,
  output logic [31:0]               s_wdata,
  input  logic                      s_gnt,
  input  logic                      s_rvalid,
  input  logic [31:0]               s_rdata
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);

  logic [IDX_W-1:0] rr_last_q, rr_last_d;
  logic             lock_vld_q, lock_vld_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             resp_vld_q, resp_vld_d;
  logic [IDX_W-1:0] resp_idx_q, resp_idx_d;
  logic             resp_err_q, resp_err_d;

  logic             has_sel;
  logic [IDX_W-1:0] sel;
  logic             sel_req;
  logic             timeout;
  logic             grant;

  // Index base+off wrapped into 0..NUM_MASTERS-1 (off never exceeds NUM_MASTERS).
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
    return IDX_W'(s);
  endfunction

  // Pick the locked master, else the first requester after the last granted one.
  // The search runs from the farthest candidate inward so the nearest one wins.
  always_comb begin
    logic [IDX_W-1:0] cand;
    has_sel = 1'b0;
    sel     = '0;
    cand    = '0;
    if (lock_vld_q) begin
      has_sel = 1'b1;
      sel     = lock_idx_q;
    end else begin
      for (int off = NUM_MASTERS; off >= 1; off--) begin
        cand = wrap_idx(rr_last_q, off);
        if (m_req[cand]) begin
          has_sel = 1'b1;
          sel     = cand;
        end
      end
    end
  end

  assign sel_req = has_sel & m_req[sel];
  assign timeout = lock_vld_q & (wait_cnt_q == CNT_W'(WAIT_TIMEOUT - 1));
  // A master that dropped its request is never granted, even on timeout.
  assign grant   = sel_req & (s_gnt | timeout);

  // Forward the selected master's transfer to the slave (master 0 when idle).
  always_comb begin
    s_req   = sel_req;
    s_we    = m_we[0];
    s_be    = m_be[3:0];
    s_addr  = m_addr[31:0];
    s_wdata = m_wdata[31:0];
    for (int i = 1; i < NUM_MASTERS; i++) begin
      if (sel == IDX_W'(i)) begin
        s_we    = m_we[i];
        s_be    = m_be[4*i +: 4];
        s_addr  = m_addr[32*i +: 32];
        s_wdata = m_wdata[32*i +: 32];
      end
    end
  end

  // Decode the one-hot grant and the routed response valid.
  always_comb begin
    m_gnt    = '0;
    m_rvalid = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_gnt[i]    = grant & (sel == IDX_W'(i));
      m_rvalid[i] = resp_vld_q & (resp_idx_q == IDX_W'(i));
    end
  end

  assign m_rdata = resp_err_q ? ERR_RDATA : s_rdata;
  assign m_err   = resp_vld_q & resp_err_q;

  // Next state: a stalled selected request holds the lock and ages; anything else clears it.
  always_comb begin
    lock_vld_d = 1'b0;
    lock_idx_d = lock_idx_q;
    wait_cnt_d = '0;
    if (sel_req & ~grant) begin
      lock_vld_d = 1'b1;
      lock_idx_d = sel;
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
    rr_last_d  = grant ? sel : rr_last_q;
    resp_vld_d = grant;
    resp_idx_d = grant ? sel : resp_idx_q;
    resp_err_d = grant & timeout;
  end

  // State registers; reset makes master 0 the first winner and drops any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q  <= IDX_W'(NUM_MASTERS - 1);
      lock_vld_q <= 1'b0;
      lock_idx_q <= '0;
      wait_cnt_q <= '0;
      resp_vld_q <= 1'b0;
      resp_idx_q <= '0;
      resp_err_q <= 1'b0;
    end else begin
      rr_last_q  <= rr_last_d;
      lock_vld_q <= lock_vld_d;
      lock_idx_q <= lock_idx_d;
      wait_cnt_q <= wait_cnt_d;
      resp_vld_q <= resp_vld_d;
      resp_idx_q <= resp_idx_d;
      resp_err_q <= resp_err_d;
    end
  end

`ifndef SYNTHESIS
  // Slave responses must line up with the non-error responses the arbiter routes.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (s_rvalid == (resp_vld_q & ~resp_err_q))
        else $error("uart_bus_arbiter: s_rvalid misaligned with routed response");
    end
  end
`endif

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Bench for uart_bus_arbiter: directed vector table, hand-written corner
// sequences, and randomized traffic checked against a cycle-stamp reference model.
module tb_uart_bus_arbiter;

  localparam int          NM  = 2;
  localparam int          WT  = 16;
  localparam logic [31:0] ERR = 32'hBAD0_0ADD;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NM-1:0]     m_req = '0;
  logic [NM-1:0]     m_we = '0;
  logic [4*NM-1:0]   m_be = '0;
  logic [32*NM-1:0]  m_addr = '0;
  logic [32*NM-1:0]  m_wdata = '0;
  logic [NM-1:0]     m_gnt;
  logic [NM-1:0]     m_rvalid;
  logic [31:0]       m_rdata;
  logic              m_err;
  logic              s_req, s_we;
  logic [3:0]        s_be;
  logic [31:0]       s_addr, s_wdata;
  logic              s_gnt;
  logic              s_rvalid;
  logic [31:0]       s_rdata;
  logic              slv_rdy = 1'b1;

  int checks = 0;
  int errors = 0;

  uart_bus_arbiter #(.NUM_MASTERS(NM), .WAIT_TIMEOUT(WT), .ERR_RDATA(ERR)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
    .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  // UART slave model: grants at once when ready, never grants offset 0xFFC.
  function automatic logic [31:0] slv_val(input logic [31:0] a);
    return {20'hC0DE0, a[11:0]};
  endfunction

  assign s_gnt = s_req & slv_rdy & (s_addr[11:0] != 12'hFFC);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_rvalid <= 1'b0;
      s_rdata  <= 32'h0;
    end else begin
      s_rvalid <= s_req & s_gnt;
      if (s_req & s_gnt) s_rdata <= s_we ? 32'h0 : slv_val(s_addr);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_m(input int i, input logic req, input logic we, input logic [31:0] addr);
    m_req[i]            = req;
    m_we[i]             = we;
    m_addr[32*i +: 32]  = addr;
    m_wdata[32*i +: 32] = $urandom;
    m_be[4*i +: 4]      = 4'hF;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    m_req   = '0;
    slv_rdy = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // m0 hits the never-granted offset while m1 waits behind it.
  task automatic run_timeout(input string tag);
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      set_m(0, (c < 16), 1'b0, 32'h0000_0FFC);
      set_m(1, (c < 17), 1'b0, 32'h0000_0004);
      #1;
      if (c < 15) chk({tag, "_blocked_gnt"}, 32'(m_gnt), 32'h0);
      if (c == 15) begin
        chk({tag, "_to_gnt"}, 32'(m_gnt), 32'h1);
        chk({tag, "_to_rvalid0"}, 32'(m_rvalid), 32'h0);
      end
      if (c == 16) begin
        chk({tag, "_err_rvalid"}, 32'(m_rvalid), 32'h1);
        chk({tag, "_err_flag"}, 32'(m_err), 32'h1);
        chk({tag, "_err_rdata"}, m_rdata, ERR);
        chk({tag, "_m1_gnt"}, 32'(m_gnt), 32'h2);
      end
      if (c == 17) begin
        chk({tag, "_m1_rvalid"}, 32'(m_rvalid), 32'h2);
        chk({tag, "_m1_err"}, 32'(m_err), 32'h0);
        chk({tag, "_m1_rdata"}, m_rdata, 32'hC0DE_0004);
        chk({tag, "_idle_gnt"}, 32'(m_gnt), 32'h0);
      end
    end
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [1:0]  gnt;
    logic [1:0]  rv;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[15];

  // Reference model state: cycle stamps rather than counters.
  int          last, locked, lock_t, own, pidx;
  bit          pv, perr, acc, to;
  logic [31:0] prd, a;
  logic [NM-1:0] eg, erv, pg;

  initial begin
    // m0 reads at 0x000, m1 at 0x004; slave always ready.
    tbl[0]  = '{2'b11, 2'b00, 2'b01, 2'b00, 1'b0, 32'h0};
    tbl[1]  = '{2'b11, 2'b00, 2'b10, 2'b01, 1'b0, 32'hC0DE_0000};
    tbl[2]  = '{2'b11, 2'b00, 2'b01, 2'b10, 1'b0, 32'hC0DE_0004};
    tbl[3]  = '{2'b11, 2'b00, 2'b10, 2'b01, 1'b0, 32'hC0DE_0000};
    tbl[4]  = '{2'b11, 2'b00, 2'b01, 2'b10, 1'b0, 32'hC0DE_0004};
    tbl[5]  = '{2'b11, 2'b00, 2'b10, 2'b01, 1'b0, 32'hC0DE_0000};
    tbl[6]  = '{2'b11, 2'b00, 2'b01, 2'b10, 1'b0, 32'hC0DE_0004};
    tbl[7]  = '{2'b11, 2'b00, 2'b10, 2'b01, 1'b0, 32'hC0DE_0000};
    tbl[8]  = '{2'b01, 2'b00, 2'b01, 2'b10, 1'b0, 32'hC0DE_0004};
    tbl[9]  = '{2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 32'hC0DE_0000};
    tbl[10] = '{2'b10, 2'b10, 2'b10, 2'b00, 1'b0, 32'h0};
    tbl[11] = '{2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 32'h0};
    tbl[12] = '{2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 32'h0};
    tbl[13] = '{2'b00, 2'b00, 2'b00, 2'b10, 1'b0, 32'h0};
    tbl[14] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0};

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_gnt", 32'(m_gnt), 32'h0);
    chk("rst_rvalid", 32'(m_rvalid), 32'h0);
    chk("rst_err", 32'(m_err), 32'h0);
    chk("rst_sreq", 32'(s_req), 32'h0);
    chk("rst_rdata", m_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Contention, single read, back-to-back writes
    for (int r = 0; r < 15; r++) begin
      @(negedge clk);
      set_m(0, tbl[r].req[0], tbl[r].we[0], 32'h0000_0000);
      set_m(1, tbl[r].req[1], tbl[r].we[1], 32'h0000_0004);
      #1;
      chk($sformatf("vec%0d_gnt", r), 32'(m_gnt), 32'(tbl[r].gnt));
      chk($sformatf("vec%0d_rvalid", r), 32'(m_rvalid), 32'(tbl[r].rv));
      chk($sformatf("vec%0d_err", r), 32'(m_err), 32'(tbl[r].err));
      if (tbl[r].rv != 2'b00) chk($sformatf("vec%0d_rdata", r), m_rdata, tbl[r].rdata);
    end

    // Timeout with a competing master
    do_reset();
    run_timeout("to");

    // Reset right after a grant: its response must never appear
    do_reset();
    @(negedge clk);
    set_m(1, 1'b1, 1'b0, 32'h0000_0004);
    #1;
    chk("prerst_gnt", 32'(m_gnt), 32'h2);
    #1;
    rst_n = 1'b0;
    m_req = '0;
    #1;
    chk("inrst_gnt", 32'(m_gnt), 32'h0);
    chk("inrst_rvalid", 32'(m_rvalid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst_rvalid", 32'(m_rvalid), 32'h0);

    // Reset in cycle 5 of a timeout wait
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      set_m(0, 1'b1, 1'b0, 32'h0000_0FFC);
      set_m(1, 1'b1, 1'b0, 32'h0000_0004);
      #1;
      chk("midlock_gnt", 32'(m_gnt), 32'h0);
    end
    #1;
    rst_n = 1'b0;
    m_req = '0;
    #1;
    chk("midlock_rst_gnt", 32'(m_gnt), 32'h0);
    chk("midlock_rst_rvalid", 32'(m_rvalid), 32'h0);
    chk("midlock_rst_err", 32'(m_err), 32'h0);
    chk("midlock_rst_sreq", 32'(s_req), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_timeout("rel");

    // Locked master drops its request
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      set_m(1, (c < 4), 1'b0, 32'h0000_0FFC);
      set_m(0, (c == 4 || c == 5), 1'b0, 32'h0000_0000);
      #1;
      if (c <= 4) chk("drop_gnt_wait", 32'(m_gnt), 32'h0);
      if (c == 5) begin
        chk("drop_m0_gnt", 32'(m_gnt), 32'h1);
        chk("drop_no_rvalid", 32'(m_rvalid), 32'h0);
      end
      if (c == 6) begin
        chk("drop_m0_rvalid", 32'(m_rvalid), 32'h1);
        chk("drop_m0_err", 32'(m_err), 32'h0);
        chk("drop_m0_rdata", m_rdata, 32'hC0DE_0000);
      end
    end

    // Randomized traffic against the reference model
    do_reset();
    last = NM - 1; locked = -1; lock_t = 0; pv = 1'b0; perr = 1'b0; pidx = 0;
    prd = '0; pg = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NM; i++) begin
        if (m_req[i] && !pg[i]) begin
          if ($urandom_range(0, 19) == 0) m_req[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          a = ($urandom_range(0, 7) == 0) ? 32'h0000_0FFC : ($urandom & 32'hFFFF_FFFC);
          set_m(i, 1'b1, ($urandom_range(0, 1) == 1), a);
        end else begin
          m_req[i] = 1'b0;
        end
      end
      slv_rdy = ($urandom_range(0, 9) < 7);
      #1;
      erv = '0;
      if (pv) erv[pidx] = 1'b1;
      chk("rnd_rvalid", 32'(m_rvalid), 32'(erv));
      chk("rnd_err", 32'(m_err), 32'(pv & perr));
      if (pv) chk("rnd_rdata", m_rdata, prd);
      own = -1;
      if (locked >= 0) own = locked;
      else begin
        for (int k = 1; k <= NM; k++) begin
          if (m_req[(last + k) % NM]) begin
            own = (last + k) % NM;
            break;
          end
        end
      end
      eg = '0;
      pv = 1'b0;
      if (own >= 0 && m_req[own]) begin
        acc = slv_rdy && (m_addr[32*own +: 12] != 12'hFFC);
        to  = (locked >= 0) && (c - lock_t == WT - 1);
        if (acc || to) begin
          eg[own] = 1'b1;
          pv      = 1'b1;
          pidx    = own;
          perr    = to;
          prd     = to ? ERR : (m_we[own] ? 32'h0 : slv_val(m_addr[32*own +: 32]));
          last    = own;
          locked  = -1;
        end else if (locked < 0) begin
          locked = own;
          lock_t = c;
        end
      end else begin
        locked = -1;
      end
      chk("rnd_gnt", 32'(m_gnt), 32'(eg));
      pg = eg;
    end
    @(negedge clk);
    m_req = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
